// File: rtl/pkt_byte_packer.sv
// pkt_byte_packer
//   Packs a byte-serial packet stream (valid/last) into DATA_WIDTH-bit words
//   for the downstream packet field parser. The earliest byte of each word
//   lands in the least-significant lane; unfilled lanes are zero.
//
// Parameters
//   DATA_WIDTH     output word width in bits (multiple of 8, >= 16)
//   MAX_PKT_BYTES  longest accepted packet, in bytes (length check only)
//
// Ports
//   Clk, Rst           clock; synchronous active-high reset
//   In_Valid/In_Byte   byte strobe and byte
//   In_Last            final byte of a packet (qualified by In_Valid)
//   In_Ready           low only while Rst is asserted
//   OutBus_DataValid   one-cycle word strobe
//   OutBus_DataSop     first word of a packet
//   OutBus_DataEop     last word of a packet
//   OutBus_Mod         valid byte count at Eop (0 = all lanes), 0 otherwise
//   OutBus_Data        packed word
//   err_oversize       one-cycle pulse alongside a truncated packet's last word
//
// Build option
//   PACKER_MAXLEN_CHECK_EN  enables the MAX_PKT_BYTES length check. Without it
//   err_oversize stays 0 and packets of any length pass through.

module pkt_byte_packer #(
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_PKT_BYTES = 1518
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              In_Valid,
  input  logic [7:0]                        In_Byte,
  input  logic                              In_Last,
  output logic                              In_Ready,
  output logic                              OutBus_DataValid,
  output logic                              OutBus_DataSop,
  output logic                              OutBus_DataEop,
  output logic [$clog2(DATA_WIDTH/8)-1:0]   OutBus_Mod,
  output logic [DATA_WIDTH-1:0]             OutBus_Data,
  output logic                              err_oversize
);

  localparam int W  = DATA_WIDTH / 8;
  localparam int LW = $clog2(W);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 16 ||
      MAX_PKT_BYTES < 1 || MAX_PKT_BYTES > 65535) begin : g_bad_params
    $error("pkt_byte_packer: illegal DATA_WIDTH or MAX_PKT_BYTES");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DISCARD
  } state_t;

  state_t                  state;
  logic [LW-1:0]           lane;
  logic [DATA_WIDTH-1:0]   asm_q;
  logic                    first_word;

  logic [LW-1:0]           cur_lane;
  logic [DATA_WIDTH-1:0]   word_nxt;
  logic [LW-1:0]           mod_nxt;
  logic                    full;
  logic                    trunc;
  logic                    emit;

  assign In_Ready = ~Rst;

  // The IDLE state folds the first byte into lane 0 of a cleared word, so
  // the completing-byte word is formed the same way in IDLE and FILL.
  always_comb begin
    cur_lane = (state == S_IDLE) ? '0 : lane;
    word_nxt = (state == S_IDLE) ? '0 : asm_q;
    for (int unsigned i = 0; i < W; i++) begin
      if (LW'(i) == cur_lane) word_nxt[8*i +: 8] = In_Byte;
    end
    full    = (cur_lane == LW'(W - 1));
    mod_nxt = full ? '0 : LW'(cur_lane + 1'b1);
  end

`ifdef PACKER_MAXLEN_CHECK_EN
  logic [15:0] byte_cnt;
  logic [15:0] cnt_nxt;

  always_comb begin
    if (state == S_IDLE)          cnt_nxt = 16'd1;
    else if (byte_cnt == 16'hFFFF) cnt_nxt = byte_cnt;
    else                           cnt_nxt = byte_cnt + 16'd1;
    // A packet of exactly MAX_PKT_BYTES ends on its own In_Last: no error.
    trunc = (cnt_nxt == 16'(MAX_PKT_BYTES)) && !In_Last;
  end

  always_ff @(posedge Clk) begin
    if (Rst)                                byte_cnt <= '0;
    else if (In_Valid && state != S_DISCARD) byte_cnt <= cnt_nxt;
  end
`else
  assign trunc = 1'b0;
`endif

  assign emit = full || In_Last || trunc;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state            <= S_IDLE;
      lane             <= '0;
      asm_q            <= '0;
      first_word       <= 1'b0;
      OutBus_DataValid <= 1'b0;
      OutBus_DataSop   <= 1'b0;
      OutBus_DataEop   <= 1'b0;
      OutBus_Mod       <= '0;
      OutBus_Data      <= '0;
      err_oversize     <= 1'b0;
    end else begin
      OutBus_DataValid <= 1'b0;
      OutBus_DataSop   <= 1'b0;
      OutBus_DataEop   <= 1'b0;
      OutBus_Mod       <= '0;
      OutBus_Data      <= '0;
      err_oversize     <= 1'b0;
      if (In_Valid) begin
        if (state == S_DISCARD) begin
          if (In_Last) state <= S_IDLE;
        end else if (emit) begin
          OutBus_DataValid <= 1'b1;
          OutBus_DataSop   <= (state == S_IDLE) || first_word;
          OutBus_DataEop   <= In_Last || trunc;
          OutBus_Mod       <= (In_Last || trunc) ? mod_nxt : '0;
          OutBus_Data      <= word_nxt;
          err_oversize     <= trunc;
          lane             <= '0;
          asm_q            <= '0;
          first_word       <= 1'b0;
          if (In_Last)    state <= S_IDLE;
          else if (trunc) state <= S_DISCARD;
          else            state <= S_FILL;
        end else begin
          asm_q      <= word_nxt;
          lane       <= cur_lane + 1'b1;
          first_word <= (state == S_IDLE) || first_word;
          state      <= S_FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_byte_packer.sv
module tb_pkt_byte_packer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        In_Valid;
  logic [7:0]  In_Byte;
  logic        In_Last;
  logic        In_Ready;
  logic        OutBus_DataValid;
  logic        OutBus_DataSop;
  logic        OutBus_DataEop;
  logic [2:0]  OutBus_Mod;
  logic [63:0] OutBus_Data;
  logic        err_oversize;

  int tests = 0;
  int fails = 0;

  pkt_byte_packer #(.DATA_WIDTH(64), .MAX_PKT_BYTES(10)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .In_Valid         (In_Valid),
    .In_Byte          (In_Byte),
    .In_Last          (In_Last),
    .In_Ready         (In_Ready),
    .OutBus_DataValid (OutBus_DataValid),
    .OutBus_DataSop   (OutBus_DataSop),
    .OutBus_DataEop   (OutBus_DataEop),
    .OutBus_Mod       (OutBus_Mod),
    .OutBus_Data      (OutBus_Data),
    .err_oversize     (err_oversize)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full output-bus check, including err_oversize.
  task automatic chk_word(input string tag, input logic v, input logic s, input logic e,
                          input logic [2:0] m, input logic [63:0] d, input logic err);
    chk({tag, ".valid"}, 64'(OutBus_DataValid), 64'(v));
    chk({tag, ".sop"},   64'(OutBus_DataSop),   64'(s));
    chk({tag, ".eop"},   64'(OutBus_DataEop),   64'(e));
    chk({tag, ".mod"},   64'(OutBus_Mod),       64'(m));
    chk({tag, ".data"},  OutBus_Data,           d);
    chk({tag, ".err"},   64'(err_oversize),     64'(err));
  endtask

  // Present one byte for one clock edge; outputs are sampled 1 ns after it.
  task automatic send(input logic [7:0] b, input logic l);
    In_Valid = 1'b1;
    In_Byte  = b;
    In_Last  = l;
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
    In_Last  = 1'b0;
    In_Byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    Rst = 1'b1; In_Valid = 1'b0; In_Byte = 8'h00; In_Last = 1'b0;
    idle(3);
    chk("reset.ready", 64'(In_Ready), 64'd0);
    chk_word("reset", 0, 0, 0, 3'd0, 64'h0, 0);
    Rst = 1'b0;
    #1;
    chk("post_reset.ready", 64'(In_Ready), 64'd1);
    idle(1);

    // Single-byte packet
    send(8'hA5, 1'b1);
    chk_word("single", 1, 1, 1, 3'd1, 64'h00000000000000A5, 0);
    idle(1);
    chk("single.pulse", 64'(OutBus_DataValid), 64'd0);

    // Exactly one full word; the next packet starts right after In_Last
    for (int i = 1; i <= 7; i++) begin
      send(8'(i), 1'b0);
      chk("p8.nov", 64'(OutBus_DataValid), 64'd0);
    end
    send(8'h08, 1'b1);
    chk_word("p8", 1, 1, 1, 3'd0, 64'h0807060504030201, 0);

    // 11-byte packet, back-to-back with the previous one
    for (int i = 1; i <= 7; i++) send(8'(i), 1'b0);
    send(8'h08, 1'b0);
    chk_word("p11.w1", 1, 1, 0, 3'd0, 64'h0807060504030201, 0);
    send(8'h09, 1'b0);
    chk("p11.nov", 64'(OutBus_DataValid), 64'd0);
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b1);
    chk_word("p11.w2", 1, 0, 1, 3'd3, 64'h00000000000B0A09, 0);
    idle(2);

    // 5-byte packet with a 3-cycle In_Valid gap after byte 2
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("gap.nov", 64'(OutBus_DataValid), 64'd0);
    end
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    chk("gap.nov4", 64'(OutBus_DataValid), 64'd0);
    send(8'h05, 1'b1);
    chk_word("gap", 1, 1, 1, 3'd5, 64'h0000000504030201, 0);
    idle(2);

    // Reset after byte 4 of a 12-byte packet, then a fresh 2-byte packet
    for (int i = 1; i <= 4; i++) send(8'(8'h40 + i), 1'b0);
    Rst = 1'b1;
    #1;
    chk("midrst.ready", 64'(In_Ready), 64'd0);
    idle(1);
    chk_word("midrst", 0, 0, 0, 3'd0, 64'h0, 0);
    Rst = 1'b0;
    send(8'hEE, 1'b0);
    chk("fresh.nov", 64'(OutBus_DataValid), 64'd0);
    send(8'hFF, 1'b1);
    chk_word("fresh", 1, 1, 1, 3'd2, 64'h000000000000FFEE, 0);
    idle(2);

`ifdef PACKER_MAXLEN_CHECK_EN
    // Exactly MAX_PKT_BYTES (10) bytes: no error
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    chk_word("max10.w1", 1, 1, 0, 3'd0, 64'h0807060504030201, 0);
    send(8'h09, 1'b0);
    send(8'h0A, 1'b1);
    chk_word("max10.w2", 1, 0, 1, 3'd2, 64'h0000000000000A09, 0);
    idle(1);

    // 20-byte packet truncated at byte 10, tail discarded
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    chk_word("over.w1", 1, 1, 0, 3'd0, 64'h0807060504030201, 0);
    send(8'h09, 1'b0);
    send(8'h0A, 1'b0);
    chk_word("over.w2", 1, 0, 1, 3'd2, 64'h0000000000000A09, 1);
    for (int i = 11; i <= 20; i++) begin
      send(8'(i), (i == 20));
      chk_word("over.drop", 0, 0, 0, 3'd0, 64'h0, 0);
    end
    send(8'h33, 1'b1);
    chk_word("over.next", 1, 1, 1, 3'd1, 64'h0000000000000033, 0);
    idle(1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pkt_byte_packer.md
Name: pkt_byte_packer

Overview:
- Ingress stage that sits directly upstream of the packet field parser.
- Packs a byte-serial packet stream (valid/last) into DATA_WIDTH-bit words on the InBus_* protocol the parser consumes (Sop/Eop/Valid/Mod/Data).
- Byte order: first byte received lands in the LSB lane, so a word is {B7,...,B0} with B0 the earliest byte.
- Also flags and truncates oversize packets so downstream stages never see unbounded packets.

Parameters:
- DATA_WIDTH, 64, output word width in bits; multiple of 8, at least 16.
- MAX_PKT_BYTES, 1518, maximum accepted packet length in bytes; only used when PACKER_MAXLEN_CHECK_EN is defined.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-high
- In_Valid  in  1  byte strobe
- In_Byte  in  8  packet byte
- In_Last  in  1  marks the final byte of a packet; qualified by In_Valid
- In_Ready  out  1  byte accepted when In_Valid & In_Ready
- OutBus_DataValid  out  1  word strobe, single-cycle pulse
- OutBus_DataSop  out  1  first word of a packet
- OutBus_DataEop  out  1  last word of a packet
- OutBus_Mod  out  $clog2(DATA_WIDTH/8)  valid byte count at Eop; 0 means all lanes valid; 0 when not Eop
- OutBus_Data  out  DATA_WIDTH  packed word; unused lanes are zero
- err_oversize  out  1  one-cycle pulse when a packet is truncated

Behaviour:
- Let W = DATA_WIDTH/8. Internal state:
  - shift/assembly register
  - lane index 0..W-1
  - first_word flag
  - packet byte counter, 16 bits, saturating
- In_Ready is high in every state except during Rst. This block has no output backpressure; the downstream parser always accepts.
- FSM states:
  - IDLE: waiting for the first byte.
  - FILL: inside a packet.
  - DISCARD: dropping the tail of an oversize packet.
- IDLE:
  - On an accepted byte: write it to lane 0, set lane=1 and first_word=1, byte count=1.
  - If In_Last is also set, emit immediately (see below) and stay in IDLE.
  - Otherwise go to FILL.
- FILL:
  - Each accepted byte goes to lane[lane] and lane increments.
  - When lane reaches W-1 and the byte is accepted, or In_Last is accepted, emit a word.
  - After emit: lane=0, first_word=0, assembly register cleared.
  - On In_Last, return to IDLE.
- Emit:
  - Happens the cycle after the completing byte: OutBus_DataValid=1 for exactly one cycle.
  - Sop=first_word.
  - Eop=In_Last, or forced Eop under truncation.
  - Mod=(bytes in word) mod W.
  - Data=assembled lanes, unfilled lanes 0.
- Latency: the completing byte is accepted at edge N; the word is valid during cycle N+1.
- Back-to-back packets:
  - A new packet's first byte may arrive on the cycle after In_Last.
  - The output then carries the previous packet's Eop word in that cycle.
  - The new packet's Sop word follows later, with no conflict.
- In_Valid gaps inside a packet are allowed. Lanes hold their values and no word is emitted.
- Packet lengths and output words:
  - Single-byte packet: one word with Sop=1, Eop=1, Mod=1.
  - Length exactly k*W: final word has Mod=0.
- An In_Last seen in DISCARD ends discard, with no output word; next state IDLE.
- Rst mid-packet:
  - Partial word is dropped.
  - All outputs go to 0, FSM to IDLE, lane=0, counter=0.
  - The next byte after Rst is treated as a new packet's first byte.
- Reset values: every output 0 except In_Ready, which is 0 during Rst and 1 afterwards.

Optional Feature:
- Macro: PACKER_MAXLEN_CHECK_EN.
- Defined:
  - When the byte count reaches MAX_PKT_BYTES and that byte is not In_Last, the word holding it is emitted with Eop=1 and the matching Mod.
  - err_oversize pulses together with that word.
  - The FSM enters DISCARD and drops bytes up to and including In_Last.
  - A packet of exactly MAX_PKT_BYTES bytes is not an error.
- Not defined:
  - No length check; err_oversize is tied to 0 and DISCARD is unreachable.
  - The counter may be removed; packets of any length pass through.

Test Plan:
- Single byte 0xA5 with In_Last, W=8 -> one cycle later: Valid=1, Sop=1, Eop=1, Mod=1, Data=0x00000000000000A5.
- 8-byte packet 0x01..0x08 back-to-back -> one word: Sop=1, Eop=1, Mod=0, Data=0x0807060504030201.
- 11-byte packet 0x01..0x0B -> word 1: Sop=1, Eop=0, Data=0x0807060504030201. Word 2: Sop=0, Eop=1, Mod=3, Data=0x00000000000B0A09.
- 5-byte packet with In_Valid low for 3 cycles after byte 2 -> single Eop word, Mod=5, Data=0x0000000504030201, emitted only after byte 5.
- Rst asserted after byte 4 of a 12-byte packet, then a fresh 2-byte packet 0xEE,0xFF -> no output for the aborted packet. One word: Sop=1, Eop=1, Mod=2, Data=0xFFEE.
- PACKER_MAXLEN_CHECK_EN with MAX_PKT_BYTES=10, 20-byte packet -> word 1: Sop=1, full. Word 2: Eop=1, Mod=2, err_oversize=1. Bytes 11-20 dropped. The next packet starts cleanly with Sop.
